reg_file_arbiter: RTL
=====================

# reg_file_arbiter

Arbitrates and sequences access to the 8×16 LC-3 general-purpose register file for two independent requesters: port A (CPU datapath) and port B (debug/test host). It serialises each request into one register-file cycle, with round-robin fairness and a req/ack handshake. It also runs a hardware clear sweep that zeroes R0–R7 after reset and on command. It sits between both requesters and the register file's `dr`/`sr1`/`ld_reg`/`bus_data` pins.

## Interface
- `DATA_WIDTH`, 16, register width
- `ADDR_WIDTH`, 3, register index width
- `NUM_REGS`, 8, registers swept by clear (≤ 2^ADDR_WIDTH)

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `clear_start` in 1: request a clear sweep (pulse or level).
- `busy` out 1: high while a clear is pending or running, or a transaction is in flight.
- `req_a`, `we_a` in 1: port A request; 1 = write, 0 = read.
- `addr_a` in ADDR_WIDTH, `wdata_a` in DATA_WIDTH: port A register index and write data.
- `ack_a` out 1, `rdata_a` out DATA_WIDTH: port A completion pulse and read data.
- `req_b`, `we_b`, `addr_b`, `wdata_b`, `ack_b`, `rdata_b`: port B, identical to port A.
- `rf_dr` out ADDR_WIDTH, `rf_ld_reg` out 1, `rf_bus_data` out DATA_WIDTH: register-file write port.
- `rf_sr1` out ADDR_WIDTH: register-file read select.
- `rf_sr1_data` in DATA_WIDTH: register-file combinational read data.

## Operation
- FSM states: IDLE, CLEAR, ACCESS, ACK.
- **Reset** (`reset`=0):
  - state=IDLE, clear_pending=1, clr_cnt=0, last_grant=B.
  - All outputs 0 except `busy`=1.
- **IDLE**: a transaction starts only in IDLE, with this priority:
  - clear_pending=1 → CLEAR (priority over requests).
  - Only one of req_a/req_b high → grant it.
  - Both high → grant the port that is not last_grant.
  - On grant, latch port id, we, addr and wdata into internal registers; update last_grant; go to ACCESS.
- **CLEAR**: one register per cycle.
  - Drive rf_dr=clr_cnt, rf_bus_data=0, rf_ld_reg=1.
  - clr_cnt increments each cycle.
  - After clr_cnt=NUM_REGS-1: clear clr_cnt and clear_pending, go to IDLE.
- **ACCESS**: exactly one cycle.
  - rf_sr1 = latched addr.
  - If write: rf_dr = addr, rf_bus_data = wdata, rf_ld_reg = 1.
  - Read data: rdata_x ← rf_sr1_data at the end of the cycle. For a write this is the pre-write value; rdata is don't-care to the user.
  - Next state ACK.
- **ACK**: ack_x=1 for exactly one cycle on the granted port only, then IDLE.
- **Handshake**:
  - Requester holds req, we, addr and wdata stable until it sees ack.
  - Requester drops req on the edge that ends the ack cycle.
  - A req still high in the following IDLE is treated as a new transaction.
- **Hold values**: rdata_x holds its value until that port's next read completes.
- **Idle outputs**: in IDLE and ACK, rf_ld_reg=0 and rf_dr, rf_sr1, rf_bus_data=0.
- **clear_start** sets clear_pending in any state.
  - An in-flight ACCESS/ACK completes normally; CLEAR starts at the next IDLE.
  - clear_start during CLEAR re-arms clear_pending, so a second full sweep follows.
- **busy** = (state≠IDLE) | clear_pending.

## Timing
- First clear: CLEAR occupies cycles 1–8 after reset release (cycle 0 = first edge in IDLE).
  - IDLE again at cycle 9; first grant possible at cycle 9.
- Transaction: IDLE (grant) → ACCESS → ACK = 3 cycles; ack appears 2 cycles after the grant edge.
  - rdata is valid in the ack cycle.
- Back-to-back, one port holding req: one transaction per 3 cycles.
- Both ports saturating: strict A,B alternation.
- Write visibility: a register written in ACCESS is readable by any transaction granted afterwards; no bypass is needed.
- Asynchronous reset mid-transaction or mid-clear: immediately returns to reset values, no ack is issued, and a fresh clear follows.
- Addresses are taken modulo 2^ADDR_WIDTH; no range checking.

## Test plan
- **Reset and clear**: release reset.
  - rf_ld_reg=1 for 8 consecutive cycles with rf_dr=0..7 and rf_bus_data=0.
  - busy falls at cycle 9.
- **Port A write then read**: write R3 ← 0xBEEF, then read R3.
  - ack_a pulses once per transaction, 2 cycles after each grant.
  - rdata_a=0xBEEF in the second ack cycle.
- **Simultaneous requests**: first contention after reset, A writes R1=0x1111 and B writes R1=0x2222.
  - A is granted first; B 3 cycles later.
  - A following read of R1 returns 0x2222.
- **Fairness**: both ports hold req continuously for 6 transactions.
  - Grants are A,B,A,B,A,B; no ack ever on the non-granted port.
- **clear_start during a port B write**: B writes R5=0x00FF; assert clear_start in B's ACCESS cycle.
  - B's write completes and ack_b pulses.
  - CLEAR follows and a subsequent read of R5 returns 0x0000.
- **Reset mid-transaction**: assert reset in ACCESS of a write to R2=0xAAAA.
  - No ack is issued.
  - After release, the sweep runs and a read of R2 returns 0x0000.

Source files
------------

// File: rtl/reg_file_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// reg_file_arbiter
//
// Arbitrates access to the 8x16 LC-3 general-purpose register file for two
// requesters: port A (CPU datapath) and port B (debug/test host). Every
// request becomes one register-file cycle (ACCESS) followed by a one-cycle
// acknowledge (ACK). When both ports ask at once, the port that was not
// granted last wins. A hardware sweep zeroes R0..R(NUM_REGS-1) after reset
// and whenever clear_start is seen.
//
// Ports
//   clk, reset          : clock, asynchronous active-low reset
//   clear_start         : request a clear sweep (pulse or level)
//   busy                : clear pending/running or transaction in flight
//   req_x, we_x         : port x request, 1 = write / 0 = read
//   addr_x, wdata_x     : port x register index and write data
//   ack_x, rdata_x      : port x completion pulse and read data (held)
//   rf_dr, rf_ld_reg,
//   rf_bus_data         : register-file write port
//   rf_sr1              : register-file read select
//   rf_sr1_data         : register-file combinational read data
// ---------------------------------------------------------------------------
module reg_file_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int NUM_REGS   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_start,
    output logic                  busy,

    input  logic                  req_a,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    output logic                  ack_a,
    output logic [DATA_WIDTH-1:0] rdata_a,

    input  logic                  req_b,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    output logic                  ack_b,
    output logic [DATA_WIDTH-1:0] rdata_b,

    output logic [ADDR_WIDTH-1:0] rf_dr,
    output logic                  rf_ld_reg,
    output logic [DATA_WIDTH-1:0] rf_bus_data,
    output logic [ADDR_WIDTH-1:0] rf_sr1,
    input  logic [DATA_WIDTH-1:0] rf_sr1_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        ACCESS = 2'd2,
        ACK    = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_REG = ADDR_WIDTH'(NUM_REGS - 1);

    state_t                state_q, state_d;
    logic                  clearPending_q, clearPending_d;
    logic                  clearRearm_q, clearRearm_d;
    logic [ADDR_WIDTH-1:0] clrCnt_q, clrCnt_d;
    logic                  lastGrantB_q, lastGrantB_d;
    logic                  grantB_q, grantB_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdataA_q, rdataA_d;
    logic [DATA_WIDTH-1:0] rdataB_q, rdataB_d;
    logic                  pickB;

    // State register. Reset leaves a clear pending so the register file is
    // swept before the first grant, and marks B as last granted so A wins
    // the first contention.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            clearPending_q <= 1'b1;
            clearRearm_q   <= 1'b0;
            clrCnt_q       <= '0;
            lastGrantB_q   <= 1'b1;
            grantB_q       <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            rdataA_q       <= '0;
            rdataB_q       <= '0;
        end else begin
            state_q        <= state_d;
            clearPending_q <= clearPending_d;
            clearRearm_q   <= clearRearm_d;
            clrCnt_q       <= clrCnt_d;
            lastGrantB_q   <= lastGrantB_d;
            grantB_q       <= grantB_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            rdataA_q       <= rdataA_d;
            rdataB_q       <= rdataB_d;
        end
    end

    // Next-state and output logic. The register-file pins are only non-zero
    // in CLEAR and ACCESS; ack is only raised in ACK on the granted port.
    always_comb begin
        state_d        = state_q;
        clearPending_d = clearPending_q;
        clearRearm_d   = clearRearm_q;
        clrCnt_d       = clrCnt_q;
        lastGrantB_d   = lastGrantB_q;
        grantB_d       = grantB_q;
        we_d           = we_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rdataA_d       = rdataA_q;
        rdataB_d       = rdataB_q;
        pickB          = 1'b0;
        rf_dr          = '0;
        rf_ld_reg      = 1'b0;
        rf_bus_data    = '0;
        rf_sr1         = '0;
        ack_a          = 1'b0;
        ack_b          = 1'b0;

        // A clear request is remembered whatever the FSM is doing; an
        // in-flight transaction finishes before the sweep starts.
        if (clear_start) begin
            clearPending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (clearPending_q) begin
                    state_d = CLEAR;
                end else if (req_a || req_b) begin
                    pickB        = (req_a && req_b) ? !lastGrantB_q : req_b;
                    grantB_d     = pickB;
                    lastGrantB_d = pickB;
                    we_d         = pickB ? we_b    : we_a;
                    addr_d       = pickB ? addr_b  : addr_a;
                    wdata_d      = pickB ? wdata_b : wdata_a;
                    state_d      = ACCESS;
                end
            end

            CLEAR: begin
                rf_dr     = clrCnt_q;
                rf_ld_reg = 1'b1;
                if (clrCnt_q == LAST_REG) begin
                    // A clear_start seen during this sweep (including now)
                    // asks for another full sweep afterwards.
                    clrCnt_d       = '0;
                    clearPending_d = clearRearm_q || clear_start;
                    clearRearm_d   = 1'b0;
                    state_d        = IDLE;
                end else begin
                    clrCnt_d = clrCnt_q + 1'b1;
                    if (clear_start) begin
                        clearRearm_d = 1'b1;
                    end
                end
            end

            ACCESS: begin
                rf_sr1 = addr_q;
                if (we_q) begin
                    rf_dr       = addr_q;
                    rf_bus_data = wdata_q;
                    rf_ld_reg   = 1'b1;
                end else if (grantB_q) begin
                    rdataB_d = rf_sr1_data;
                end else begin
                    rdataA_d = rf_sr1_data;
                end
                state_d = ACK;
            end

            ACK: begin
                ack_a   = !grantB_q;
                ack_b   = grantB_q;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy    = (state_q != IDLE) || clearPending_q;
    assign rdata_a = rdataA_q;
    assign rdata_b = rdataB_q;

endmodule
